// File: rtl/hack_run_monitor.sv
// Hack SoC run monitor: detects the terminating jump loop (or a timeout), then
// checks shadowed RAM locations against expected values and reports pass/fail.
module hack_run_monitor #(
    parameter int PC_W           = 15,
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int NUM_CHECK      = 4,
    parameter int IDX_W          = 2,
    parameter logic [NUM_CHECK*ADDR_W-1:0] CHECK_ADDRS = {15'd3, 15'd2, 15'd1, 15'd0},
    parameter logic [NUM_CHECK*DATA_W-1:0] EXP_VALUES  = {16'd0, 16'd0, 16'd0, 16'd30},
    parameter int HALT_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_writeM,
    input  logic [ADDR_W-1:0] i_addressM,
    input  logic [DATA_W-1:0] i_outM,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [IDX_W-1:0]  o_fail_idx,
    output logic [DATA_W-1:0] o_fail_value,
    output logic [CNT_W-1:0]  o_cycles
);

    localparam int LC_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [LC_W-1:0]  HALT_LAST = LC_W'(HALT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHECK - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shadow [NUM_CHECK];
    logic [NUM_CHECK-1:0] r_valid;
    logic [PC_W-1:0]     r_pc_d1;
    logic [PC_W-1:0]     r_pc_d2;
    logic                r_v_d1;
    logic                r_v_d2;
    logic [LC_W-1:0]     r_loop_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic                w_loop_hit;
    logic                w_halt;
    logic                w_tmo;
    logic [DATA_W-1:0]   w_cur_shadow;
    logic [DATA_W-1:0]   w_cur_exp;
    logic                w_mismatch;

    // A one-instruction loop repeats the previous PC; a two-instruction loop the one before.
    assign w_loop_hit   = (r_v_d1 && (i_pc == r_pc_d1)) || (r_v_d2 && (i_pc == r_pc_d2));
    assign w_halt       = w_loop_hit && (r_loop_cnt == HALT_LAST);
    assign w_tmo        = (o_cycles == TMO_LAST);
    assign w_cur_shadow = r_shadow[r_idx];
    assign w_cur_exp    = EXP_VALUES[int'(r_idx) * DATA_W +: DATA_W];
    assign w_mismatch   = !r_valid[r_idx] || (w_cur_shadow != w_cur_exp);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_timeout    <= 1'b0;
            o_fail_idx   <= '0;
            o_fail_value <= '0;
            o_cycles     <= '0;
            r_valid      <= '0;
            for (int unsigned k = 0; k < NUM_CHECK; k++) r_shadow[k] <= '0;
            r_pc_d1      <= '0;
            r_pc_d2      <= '0;
            r_v_d1       <= 1'b0;
            r_v_d2       <= 1'b0;
            r_loop_cnt   <= '0;
            r_idx        <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state      <= S_RUN;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_pass       <= 1'b0;
                        o_timeout    <= 1'b0;
                        o_fail_idx   <= '0;
                        o_fail_value <= '0;
                        o_cycles     <= '0;
                        r_valid      <= '0;
                        for (int unsigned k = 0; k < NUM_CHECK; k++) r_shadow[k] <= '0;
                        r_v_d1       <= 1'b0;
                        r_v_d2       <= 1'b0;
                        r_loop_cnt   <= '0;
                        r_idx        <= '0;
                    end
                end
                S_RUN: begin
                    if (o_cycles != '1) o_cycles <= o_cycles + 1'b1;
                    for (int unsigned k = 0; k < NUM_CHECK; k++) begin
                        if (i_writeM && (i_addressM == CHECK_ADDRS[k*ADDR_W +: ADDR_W])) begin
                            r_shadow[k] <= i_outM;
                            r_valid[k]  <= 1'b1;
                        end
                    end
                    r_pc_d1    <= i_pc;
                    r_pc_d2    <= r_pc_d1;
                    r_v_d1     <= 1'b1;
                    r_v_d2     <= r_v_d1;
                    r_loop_cnt <= w_loop_hit ? r_loop_cnt + 1'b1 : '0;
                    // Halt takes priority over a coincident timeout.
                    if (w_halt) begin
                        r_state <= S_CHECK;
                        r_idx   <= '0;
                    end else if (w_tmo) begin
                        r_state   <= S_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_timeout <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_state      <= S_DONE;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_fail_idx   <= r_idx;
                        o_fail_value <= w_cur_shadow;
                    end else if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        o_pass  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hack_run_monitor.md
Name: hack_run_monitor

Overview:
- Synthesizable run monitor for the Hack SoC. It watches the CPU program counter and data-memory write bus.
- It detects program completion, meaning the terminating jump loop, or a timeout.
- It then checks a parametrised set of RAM locations against expected values.
- It replaces the fixed-delay, single-location RAM[0] check with an on-chip pass/fail result usable by both simulation and board LEDs.

Parameters:
PC_W, 15, program counter width
ADDR_W, 15, addressM width
DATA_W, 16, data word width
NUM_CHECK, 4, number of checked RAM locations (>=1)
IDX_W, 2, width of fail index (>= clog2(NUM_CHECK), min 1)
CHECK_ADDRS, {15'd3,15'd2,15'd1,15'd0}, packed NUM_CHECK*ADDR_W; slot k = bits [k*ADDR_W +: ADDR_W]
EXP_VALUES, {16'd0,16'd0,16'd0,16'd30}, packed NUM_CHECK*DATA_W expected values, same slot order
HALT_CYCLES, 8, consecutive loop-hit cycles that declare halt (>=1)
TIMEOUT_CYCLES, 1024, RUN cycles before timeout
CNT_W, 32, cycle counter width

Ports:
i_clk  in  1  system clock, all state on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle start pulse
i_pc  in  PC_W  CPU program counter
i_writeM  in  1  CPU data write enable
i_addressM  in  ADDR_W  CPU data address
i_outM  in  DATA_W  CPU write data
o_busy  out  1  high in RUN or CHECK
o_done  out  1  high in DONE
o_pass  out  1  all slots matched (valid only with o_done)
o_timeout  out  1  run ended by timeout
o_fail_idx  out  IDX_W  first mismatching slot
o_fail_value  out  DATA_W  captured value of that slot
o_cycles  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; all outputs 0; shadow values 0; shadow valid bits 0; counters 0; PC history invalid.
- States: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + i_start=1: next state RUN. On that edge, clear o_cycles, loop counter, check index, all shadow valid bits and values, PC history valid flags, and o_pass/o_timeout/o_fail_idx/o_fail_value.
- i_start in RUN or CHECK: ignored.
- RUN, every cycle:
  - o_cycles += 1, saturating at all-ones.
  - Capture: if i_writeM and i_addressM == CHECK_ADDRS[k], then shadow[k] <= i_outM and valid[k] <= 1, for every matching k (duplicate addresses allowed).
  - PC history: pc_d1 <= i_pc, pc_d2 <= pc_d1. Each has a valid flag, and the flag sets only after the register has been loaded in RUN.
  - loop_hit = (v_d1 && i_pc==pc_d1) || (v_d2 && i_pc==pc_d2). This covers one- and two-instruction loops, e.g. "@END / 0;JMP".
  - loop_cnt increments on loop_hit and clears to 0 on a miss.
  - Halt: loop_hit && loop_cnt == HALT_CYCLES-1 -> CHECK.
  - Timeout: o_cycles == TIMEOUT_CYCLES-1 with no halt this cycle -> DONE, o_timeout=1, o_pass=0, o_fail_idx=0, o_fail_value=0.
  - Halt and timeout in the same cycle: halt wins.
  - A write on the halt cycle is captured.
- CHECK: one slot per cycle, index 0 upward. Shadows are frozen; bus writes are ignored; o_cycles is frozen.
  - Mismatch = !valid[k] || shadow[k] != EXP_VALUES[k].
  - First mismatch -> DONE, o_pass=0, o_fail_idx=k, o_fail_value=shadow[k] (0 if never written).
  - All NUM_CHECK slots match -> DONE, o_pass=1.
  - Latency from halt detection to DONE is at most NUM_CHECK cycles.
- DONE: outputs hold until i_start or reset.
- Reset mid-RUN/CHECK: immediate return to the reset state, with no partial result.
- Outputs are registered.

Test Plan:
- Hack program computes 10+20 into RAM[0], then "@END;0;JMP". Defaults, slots 1-3 expect 0 and are written with 0 -> o_done=1, o_pass=1, o_timeout=0. o_cycles equals the instruction count to the loop plus HALT_CYCLES.
- Same program writing 29 to RAM[0] -> o_pass=0, o_fail_idx=0, o_fail_value=29.
- Slot 2 (addr 2) never written, all others correct -> o_pass=0, o_fail_idx=2, o_fail_value=0.
- PC increments forever with no loop, TIMEOUT_CYCLES=64 -> o_done at RUN cycle 64, o_timeout=1, o_pass=0, o_cycles=64.
- Two writes to RAM[1] (5 then 0), and a write to RAM[1] on the halt cycle -> last value captured, pass. A write during CHECK does not change the result.
- i_reset_n pulsed low mid-RUN -> all outputs 0 asynchronously. i_start pulsed while busy has no effect. A re-start from DONE clears the previous result and reruns correctly.
